// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller that sits in ID. It tracks in-flight destination registers,
// raises load-use stall and branch flush, and registers operand forward selects into EX.
module pipe_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_LAT   = 1,
    parameter int KILL_DEPTH = 2,
    parameter int CNT_W      = 16,
    localparam int POS_W     = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rs_i,
    input  logic                  id_uses_rt_i,
    input  logic [REG_ADDR_W-1:0] id_dst_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  br_taken_i,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [POS_W-1:0]      fwd_a_o,
    output logic [POS_W-1:0]      fwd_b_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    logic [PIPE_DEPTH:1]   sbValid_q, sbValid_d;
    logic [PIPE_DEPTH:1]   sbLoad_q, sbLoad_d;
    logic [REG_ADDR_W-1:0] sbDst_q [1:PIPE_DEPTH];
    logic [REG_ADDR_W-1:0] sbDst_d [1:PIPE_DEPTH];

    logic [POS_W-1:0] fwdA_q, fwdA_d;
    logic [POS_W-1:0] fwdB_q, fwdB_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    logic [POS_W-1:0] matchRs, matchRt;
    logic             loadUseRs, loadUseRt;
    logic             advance;

    // Scan oldest to youngest so the youngest matching producer is what remains.
    always_comb begin
        matchRs   = '0;
        matchRt   = '0;
        loadUseRs = 1'b0;
        loadUseRt = 1'b0;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (id_uses_rs_i && (id_rs_i != '0) && sbValid_q[k] && (sbDst_q[k] == id_rs_i)) begin
                matchRs   = POS_W'(k);
                loadUseRs = sbLoad_q[k] && (k <= LOAD_LAT);
            end
            if (id_uses_rt_i && (id_rt_i != '0) && sbValid_q[k] && (sbDst_q[k] == id_rt_i)) begin
                matchRt   = POS_W'(k);
                loadUseRt = sbLoad_q[k] && (k <= LOAD_LAT);
            end
        end
    end

    assign flush_o = reset_i & br_taken_i;
    assign stall_o = reset_i & id_valid_i & ~br_taken_i & (loadUseRs | loadUseRt);
    assign advance = id_valid_i & ~stall_o & ~flush_o;

    // A taken branch kills the youngest entries before they shift down one slot.
    always_comb begin
        sbValid_d = '0;
        sbLoad_d  = '0;
        for (int k = 1; k <= PIPE_DEPTH; k++) begin
            sbDst_d[k] = '0;
        end
        for (int k = PIPE_DEPTH; k >= 2; k--) begin
            sbValid_d[k] = sbValid_q[k-1] & ~(flush_o & ((k - 1) <= KILL_DEPTH));
            sbLoad_d[k]  = sbLoad_q[k-1];
            sbDst_d[k]   = sbDst_q[k-1];
        end
        sbValid_d[1] = advance & id_reg_write_i & (id_dst_i != '0);
        sbLoad_d[1]  = advance & id_mem_read_i;
        sbDst_d[1]   = advance ? id_dst_i : '0;

        fwdA_d = advance ? matchRs : '0;
        fwdB_d = advance ? matchRt : '0;

        stallCnt_d = (stall_o && (stallCnt_q != '1)) ? stallCnt_q + CNT_W'(1) : stallCnt_q;
        flushCnt_d = (flush_o && (flushCnt_q != '1)) ? flushCnt_q + CNT_W'(1) : flushCnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sbValid_q  <= '0;
            sbLoad_q   <= '0;
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                sbDst_q[k] <= '0;
            end
            fwdA_q     <= '0;
            fwdB_q     <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            sbValid_q  <= sbValid_d;
            sbLoad_q   <= sbLoad_d;
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                sbDst_q[k] <= sbDst_d[k];
            end
            fwdA_q     <= fwdA_d;
            fwdB_q     <= fwdB_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign fwd_a_o     = fwdA_q;
    assign fwd_b_o     = fwdB_q;
    assign stall_cnt_o = stallCnt_q;
    assign flush_cnt_o = flushCnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed pipeline scenarios plus random traffic
// compared against a list-of-in-flight-instructions model.
module tb_pipe_hazard_unit;

    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int KILL     = 2;
    localparam int CNT_W    = 5;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             idValid;
    logic [4:0]       idRs, idRt, idDst;
    logic             idUsesRs, idUsesRt, idRegWrite, idMemRead, brTaken;
    logic             stall, flush;
    logic [1:0]       fwdA, fwdB;
    logic [CNT_W-1:0] stallCnt, flushCnt;

    int testCount = 0;
    int failCount = 0;

    // Reference model: what is in flight at each age after ID (1 = just entered EX).
    bit         mValid [0:DEPTH];
    bit         mLoad  [0:DEPTH];
    logic [4:0] mDst   [0:DEPTH];
    int         mFwdA, mFwdB, mStallCnt, mFlushCnt;

    logic lastStall, lastFlush;

    pipe_hazard_unit #(
        .REG_ADDR_W(5), .PIPE_DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
        .KILL_DEPTH(KILL), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .reset_i(reset), .id_valid_i(idValid),
        .id_rs_i(idRs), .id_rt_i(idRt),
        .id_uses_rs_i(idUsesRs), .id_uses_rt_i(idUsesRt),
        .id_dst_i(idDst), .id_reg_write_i(idRegWrite), .id_mem_read_i(idMemRead),
        .br_taken_i(brTaken), .stall_o(stall), .flush_o(flush),
        .fwd_a_o(fwdA), .fwd_b_o(fwdB),
        .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int youngest(input logic [4:0] r);
        if (r == 5'd0) return 0;
        for (int k = 1; k <= DEPTH; k++)
            if (mValid[k] && mDst[k] == r) return k;
        return 0;
    endfunction

    // One ID cycle: drive, check combinational outputs, clock, check registered outputs.
    task automatic applyStimulus(input bit rstN, input bit v,
                                 input logic [4:0] rs, input bit ua,
                                 input logic [4:0] rt, input bit ub,
                                 input logic [4:0] dst, input bit wr, input bit ld, input bit br);
        int  ka, kb;
        bit  expStall, expFlush, adv;
        @(negedge clk);
        reset = rstN; idValid = v; idRs = rs; idUsesRs = ua; idRt = rt; idUsesRt = ub;
        idDst = dst; idRegWrite = wr; idMemRead = ld; brTaken = br;
        #1;
        ka = ua ? youngest(rs) : 0;
        kb = ub ? youngest(rt) : 0;
        expStall = rstN && v && !br &&
                   ((ka != 0 && ka <= LOAD_LAT && mLoad[ka]) ||
                    (kb != 0 && kb <= LOAD_LAT && mLoad[kb]));
        expFlush = rstN && br;
        lastStall = stall;
        lastFlush = flush;
        checkOutput("stall", {31'b0, stall}, {31'b0, expStall});
        checkOutput("flush", {31'b0, flush}, {31'b0, expFlush});
        @(posedge clk);
        if (!rstN) begin
            for (int k = 0; k <= DEPTH; k++) begin
                mValid[k] = 0; mLoad[k] = 0; mDst[k] = '0;
            end
            mFwdA = 0; mFwdB = 0; mStallCnt = 0; mFlushCnt = 0;
        end else begin
            adv = v && !expStall && !expFlush;
            if (expFlush)
                for (int k = 1; k <= KILL; k++) mValid[k] = 0;
            for (int k = DEPTH; k >= 2; k--) begin
                mValid[k] = mValid[k-1]; mLoad[k] = mLoad[k-1]; mDst[k] = mDst[k-1];
            end
            mValid[1] = adv && wr && (dst != 5'd0);
            mLoad[1]  = adv && ld;
            mDst[1]   = dst;
            mFwdA = adv ? ka : 0;
            mFwdB = adv ? kb : 0;
            if (expStall && mStallCnt < CNT_MAX) mStallCnt++;
            if (expFlush && mFlushCnt < CNT_MAX) mFlushCnt++;
        end
        #1;
        checkOutput("fwd_a", {30'b0, fwdA}, mFwdA);
        checkOutput("fwd_b", {30'b0, fwdB}, mFwdB);
        checkOutput("stall_cnt", {27'b0, stallCnt}, mStallCnt);
        checkOutput("flush_cnt", {27'b0, flushCnt}, mFlushCnt);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 0; idValid = 0; idRs = 0; idRt = 0; idUsesRs = 0; idUsesRt = 0;
        idDst = 0; idRegWrite = 0; idMemRead = 0; brTaken = 0;
        lastStall = 0; lastFlush = 0;
        for (int k = 0; k <= DEPTH; k++) begin
            mValid[k] = 0; mLoad[k] = 0; mDst[k] = '0;
        end
        mFwdA = 0; mFwdB = 0; mStallCnt = 0; mFlushCnt = 0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_fwd_a", {30'b0, fwdA}, 0);
        checkOutput("rst_stall_cnt", {27'b0, stallCnt}, 0);

        // add $3,$1,$2 ; add $4,$3,$1
        applyStimulus(1, 1, 1, 1, 2, 1, 3, 1, 0, 0);
        applyStimulus(1, 1, 3, 1, 1, 1, 4, 1, 0, 0);
        checkOutput("t1_stall", {31'b0, lastStall}, 0);
        checkOutput("t1_fwd_a", {30'b0, fwdA}, 1);
        checkOutput("t1_fwd_b", {30'b0, fwdB}, 0);
        drain();

        // add $3 ; nop ; sub $5,$1,$3
        applyStimulus(1, 1, 1, 1, 2, 1, 3, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 3, 1, 5, 1, 0, 0);
        checkOutput("t2_stall", {31'b0, lastStall}, 0);
        checkOutput("t2_fwd_a", {30'b0, fwdA}, 0);
        checkOutput("t2_fwd_b", {30'b0, fwdB}, 2);
        drain();

        // lw $5,0($1) ; add $6,$5,$5 (stalls once, then forwards from MEM/WB)
        applyStimulus(1, 1, 1, 1, 0, 0, 5, 1, 1, 0);
        applyStimulus(1, 1, 5, 1, 5, 1, 6, 1, 0, 0);
        checkOutput("t3_stall1", {31'b0, lastStall}, 1);
        checkOutput("t3_stall_cnt", {27'b0, stallCnt}, 1);
        applyStimulus(1, 1, 5, 1, 5, 1, 6, 1, 0, 0);
        checkOutput("t3_stall2", {31'b0, lastStall}, 0);
        checkOutput("t3_fwd_a", {30'b0, fwdA}, 2);
        checkOutput("t3_fwd_b", {30'b0, fwdB}, 2);
        drain();

        // add $0,$1,$2 ; add $7,$0,$0
        applyStimulus(1, 1, 1, 1, 2, 1, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1, 0, 1, 7, 1, 0, 0);
        checkOutput("t4_stall", {31'b0, lastStall}, 0);
        checkOutput("t4_fwd_a", {30'b0, fwdA}, 0);
        checkOutput("t4_fwd_b", {30'b0, fwdB}, 0);
        drain();

        // lw $5 ; add $6,$5,$5 with a taken branch, then the same reader again
        applyStimulus(1, 1, 1, 1, 0, 0, 5, 1, 1, 0);
        applyStimulus(1, 1, 5, 1, 5, 1, 6, 1, 0, 1);
        checkOutput("t5_flush", {31'b0, lastFlush}, 1);
        checkOutput("t5_stall", {31'b0, lastStall}, 0);
        checkOutput("t5_flush_cnt", {27'b0, flushCnt}, 1);
        checkOutput("t5_fwd_a", {30'b0, fwdA}, 0);
        applyStimulus(1, 1, 5, 1, 5, 1, 6, 1, 0, 0);
        checkOutput("t5_killed_stall", {31'b0, lastStall}, 0);
        checkOutput("t5_killed_fwd_a", {30'b0, fwdA}, 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
        end

        drain();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 1, 1, 1, 0, 0, 5, 1, 1, 0);
            applyStimulus(1, 1, 5, 1, 5, 1, 6, 1, 0, 0);
            applyStimulus(1, 1, 5, 1, 5, 1, 6, 1, 0, 0);
        end
        checkOutput("sat_stall_cnt", {27'b0, stallCnt}, CNT_MAX);

        drain();
        applyStimulus(1, 1, 1, 1, 0, 0, 9, 1, 1, 0);
        applyStimulus(0, 1, 9, 1, 9, 1, 10, 1, 0, 0);
        checkOutput("t6_rst_stall", {31'b0, lastStall}, 0);
        checkOutput("t6_rst_stall_cnt", {27'b0, stallCnt}, 0);
        checkOutput("t6_rst_flush_cnt", {27'b0, flushCnt}, 0);
        checkOutput("t6_rst_fwd_b", {30'b0, fwdB}, 0);
        applyStimulus(1, 1, 9, 1, 9, 1, 10, 1, 0, 0);
        checkOutput("t6_forgotten_stall", {31'b0, lastStall}, 0);
        checkOutput("t6_forgotten_fwd_a", {30'b0, fwdA}, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
